// File: rtl/uart_baud_gen.sv
// UART baud-rate generator: runtime-programmable prescaler followed by an
// OVS-stage oversampling counter, producing oversample, mid-bit and end-of-bit ticks.
module uart_baud_gen #(
  parameter int unsigned DIV_W   = 8,
  parameter int unsigned OVS     = 16,
  parameter int unsigned DEF_DIV = 10
) (
  input  logic             clk,
  input  logic             rst_x,
  input  logic             baud_en,
  input  logic             baud_restart,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             div_ld,
  output logic             ovs_tick,
  output logic             baud_half,
  output logic             baud_tick,
  output logic             div_busy
);

  localparam int unsigned OVS_W = (OVS > 1) ? $clog2(OVS) : 1;
  localparam logic [OVS_W-1:0] OVS_MID  = OVS_W'(OVS / 2 - 1);
  localparam logic [OVS_W-1:0] OVS_LAST = OVS_W'(OVS - 1);
  localparam logic [DIV_W-1:0] DIV_RST  = DIV_W'(DEF_DIV);

  logic [DIV_W-1:0] pre_r;
  logic [OVS_W-1:0] ovs_r;
  logic [DIV_W-1:0] div_r;
  logic [DIV_W-1:0] div_pend_r;
  logic             pend_r;

  logic run;
  logic div_apply;

  // Ticks are also held low while reset is asserted so no stale decode escapes.
  assign run       = rst_x & baud_en & ~baud_restart;
  assign ovs_tick  = run & (pre_r == div_r);
  assign baud_half = ovs_tick & (ovs_r == OVS_MID);
  assign baud_tick = ovs_tick & (ovs_r == OVS_LAST);
  assign div_busy  = pend_r;

  // Safe points for a divisor change: the bit phase restarts from zero.
  assign div_apply = ~baud_en | baud_tick | baud_restart;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_x) begin
      pre_r  <= '0;
      ovs_r  <= '0;
      div_r  <= DIV_RST;
      pend_r <= 1'b0;
    end else begin
      if (!baud_en || baud_restart) begin
        pre_r <= '0;
        ovs_r <= '0;
      end else if (ovs_tick) begin
        pre_r <= '0;
        ovs_r <= ovs_r + OVS_W'(1);
      end else begin
        pre_r <= pre_r + DIV_W'(1);
      end

      if (div_ld) begin
        if (div_apply) begin
          div_r  <= baud_div;
          pend_r <= 1'b0;
        end else begin
          pend_r <= 1'b1;
        end
      end else if (pend_r && div_apply) begin
        div_r  <= div_pend_r;
        pend_r <= 1'b0;
      end
    end
  end

  // NOTE: the holding register is deliberately not reset; its content is only
  // consumed while pend_r is set, and pend_r is always reset.
  always_ff @(posedge clk) begin
    if (div_ld) begin
      div_pend_r <= baud_div;
    end
  end

endmodule
